// File: rtl/lab7soc_gpio_pio.sv
// rtl/lab7soc_gpio_pio.sv - Avalon-MM GPIO port with direction, set/clear, edge capture and irq
//
// Purpose:
//   General-purpose I/O slave for the lab7soc interconnect. Each bit has its own
//   direction. Output bits can be set or cleared atomically. Inputs are
//   synchronised, then edge-detected into a sticky capture register. A masked OR
//   of that register drives a level interrupt.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   reset_n    synchronous active-low reset
//   address    register word address (0..7)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data, low DATA_WIDTH bits used
//   in_port    asynchronous external inputs
//   out_port   output data register
//   oe         direction register, 1 = bit driven as output
//   readdata   combinational read data, zero-extended to 32 bits
//   irq        level interrupt, active high
//
// Register map:
//   0 DATA (read mixes outputs and synced inputs by oe), 1 DIRECTION, 2 IRQ_MASK,
//   3 EDGE_CAPTURE (write-1-to-clear), 4 OUTSET, 5 OUTCLEAR, 6/7 reserved

module lab7soc_gpio_pio #(
  parameter int unsigned           DATA_WIDTH  = 14,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           EDGE_TYPE   = 0,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // The settle counter must see the synchroniser fill plus one more cycle for
  // in_prev before both compared samples come from post-reset inputs.
  localparam int unsigned SETTLE_MAX = SYNC_STAGES + 1;
  localparam int unsigned CNT_W      = $clog2(SETTLE_MAX + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] oe_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] cap_q;
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] in_prev;
  logic [CNT_W-1:0]      settle_cnt;
  logic                  settled;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] clear_mask;
  logic [DATA_WIDTH-1:0] rd_data;

  // Bits above DATA_WIDTH are accepted from the bus but carry no meaning.
  logic unused_writedata;
  assign unused_writedata = &{1'b0, writedata};

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[DATA_WIDTH-1:0];

  // Input synchroniser and one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      in_prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      in_prev <= in_sync;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  // Saturating counter that blocks edge detection until the reset zeros have
  // been flushed out of both the synchroniser and in_prev.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + CNT_W'(1);
    end
  end

  assign settled = (settle_cnt == CNT_W'(SETTLE_MAX));

  assign rise = in_sync & ~in_prev;
  assign fall = ~in_sync & in_prev;

  always_comb begin
    edge_det = '0;
    if (settled) begin
      case (EDGE_TYPE)
        0:       edge_det = rise;
        1:       edge_det = fall;
        default: edge_det = rise | fall;
      endcase
    end
  end

  assign clear_mask = (wr_en && address == ADDR_EDGE_CAP) ? wdata : '0;

  // Capture register: a fresh edge beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_q <= '0;
    end else begin
      cap_q <= (cap_q & ~clear_mask) | edge_det;
    end
  end

  // Output data register with plain, set and clear write ports.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     out_q <= wdata;
        ADDR_OUTSET:   out_q <= out_q | wdata;
        ADDR_OUTCLEAR: out_q <= out_q & ~wdata;
        default:       out_q <= out_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      oe_q   <= '0;
      mask_q <= '0;
    end else if (wr_en) begin
      if (address == ADDR_DIR) begin
        oe_q <= wdata;
      end
      if (address == ADDR_IRQ_MASK) begin
        mask_q <= wdata;
      end
    end
  end

  // Read mux is purely combinational and ignores chipselect.
  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_DATA:     rd_data = (oe_q & out_q) | (~oe_q & in_sync);
      ADDR_DIR:      rd_data = oe_q;
      ADDR_IRQ_MASK: rd_data = mask_q;
      ADDR_EDGE_CAP: rd_data = cap_q;
      default:       rd_data = '0;
    endcase
  end

  assign readdata = 32'(rd_data);
  assign out_port = out_q;
  assign oe       = oe_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: doc/lab7soc_gpio_pio.md
Name: lab7soc_gpio_pio

Overview:
Parametrised Avalon-MM general-purpose I/O port and successor to the fixed 14-bit output-only LED PIO.
- Per-bit direction control, atomic set/clear of output bits, synchronised input sampling.
- Edge-capture register with per-bit interrupt mask and a level interrupt to the Nios II.
- Sits on the lab7soc system interconnect; drives board LEDs/headers and reads switches/keys.

Parameters:
DATA_WIDTH, 14, number of I/O bits (1..32).
RESET_VALUE, 0, reset value of the output data register (DATA_WIDTH bits).
EDGE_TYPE, 0, edge capture type: 0 = rising, 1 = falling, 2 = any.
SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
address  input  3  register word address.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe; write = chipselect & ~write_n.
writedata  input  32  write data; only [DATA_WIDTH-1:0] used.
in_port  input  DATA_WIDTH  asynchronous external inputs.
out_port  output  DATA_WIDTH  output data register.
oe  output  DATA_WIDTH  direction register; 1 = bit driven as output.
readdata  output  32  combinational read data, zero-extended above DATA_WIDTH.
irq  output  1  level interrupt, active high.

Behaviour:
Register map (word addresses):
- 0 DATA
  - read: per bit, (oe & out_port) | (~oe & in_sync).
  - write: out_port <= writedata.
- 1 DIRECTION: read/write; oe <= writedata.
- 2 IRQ_MASK: read/write.
- 3 EDGE_CAPTURE
  - read: capture bits.
  - write: write-1-to-clear per bit.
- 4 OUTSET: write: out_port <= out_port | writedata; read 0.
- 5 OUTCLEAR: write: out_port <= out_port & ~writedata; read 0.
- 6, 7: read 0; writes ignored.

Read path:
- Zero wait states, combinational from registers.
- readdata is driven regardless of chipselect.
- readdata[31:DATA_WIDTH] = 0 always.

Writes:
- Take effect on the rising clk edge where chipselect & ~write_n.
- New value is visible on out_port/oe/readdata the following cycle.

Reset (reset_n = 0 at a clk edge):
- out_port = RESET_VALUE; oe = 0; IRQ_MASK = 0; EDGE_CAPTURE = 0; irq = 0.
- All synchroniser and previous-sample flops = 0; settle counter = 0.
- Reset overrides any simultaneous write or edge.
- Reset asserted mid-operation discards pending captures.

Synchroniser:
- in_port passes through SYNC_STAGES flops to give in_sync.
- in_prev holds in_sync delayed one cycle.

Settle counter:
- Counts 0..SYNC_STAGES+1 after reset, then saturates.
- Edge detection is disabled until saturated; no spurious captures from the flops' reset values.

Edge detect:
- Per bit; applies to all bits regardless of oe.
- rise = in_sync & ~in_prev; fall = ~in_sync & in_prev.
- Selected by EDGE_TYPE; EDGE_TYPE=2 uses rise|fall.

Capture:
- capture_next = (capture & ~clear_mask) | edge.
- Set wins over a simultaneous write-1-to-clear of the same bit.

Latency:
- in_port transition just before clk edge k: in_sync changes at edge k+SYNC_STAGES-1.
- Capture bit set at edge k+SYNC_STAGES.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers, so it asserts in the same cycle the capture bit is visible.

Simultaneous writes:
- Only one address per cycle, so OUTSET/OUTCLEAR/DATA writes never conflict.

Test Plan:
1. Reset with RESET_VALUE=14'h0A5, in_port=14'h3FFF held high → out_port=0x0A5, oe=0, readdata@0=0x3FFF after sync latency; EDGE_CAPTURE stays 0 through and after the settle period.
2. Write DIRECTION=0x00FF, DATA=0x1234 → out_port=0x1234, oe=0x00FF; with in_port=0x3C00, read@0=0x3C34.
3. OUTSET 0x0003 then OUTCLEAR 0x0030 on consecutive cycles, starting from out_port=0x1234 → out_port=0x1237, then 0x1207; reads @4 and @5 = 0.
4. EDGE_TYPE=0, IRQ_MASK=0x0001, in_port bit0 0→1 before edge k → EDGE_CAPTURE=0x0001 and irq=1 after edge k+2 (SYNC_STAGES=2); a falling edge causes no change; writing 0x0001 to @3 → capture 0, irq 0 next cycle.
5. W1C write to @3 bit0 in the same cycle a new rising edge on bit0 is detected → bit0 remains 1 and irq stays high.
6. Pulse reset_n low for one cycle while EDGE_CAPTURE=0x0101 and a DATA write of 0x3FFF is issued → all registers at reset values, irq=0, write discarded; unmasked captured bit with IRQ_MASK=0 never raises irq.
